apb_master_bridge: RTL and testbench

- Upstream APB requester for the 16 x 8-bit APB register slave.
- Takes single read/write commands from a simple valid/ready command port and runs standard two-phase APB transfers (SETUP then ACCESS).
- Returns one response per command: read data, slave error, or timeout.
- Keeps saturating transfer and error counters for debug.

---
 rtl/apb_master_bridge.sv | 149 ++++++++++++++
 tb/tb_apb_master_bridge.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB requester: turns single valid/ready commands into SETUP/ACCESS transfers,
// returning one response per command with optional ACCESS-phase timeout.
module apb_master_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr,
  output logic [CNT_WIDTH-1:0]  xfer_count,
  output logic [CNT_WIDTH-1:0]  err_count
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                state_q, state_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [CNT_WIDTH-1:0]  xfer_q, xfer_d;
  logic [CNT_WIDTH-1:0]  errc_q, errc_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic                  accept;

  assign cmd_ready   = (state_q == IDLE) && presetn;
  assign accept      = cmd_valid && cmd_ready;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign xfer_count  = xfer_q;
  assign err_count   = errc_q;

  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    xfer_d        = xfer_q;
    errc_d        = errc_q;
    tcnt_d        = tcnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          psel_d   = 1'b1;
          tcnt_d   = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        tcnt_d = tcnt_q + TW'(1);
        // pready has priority over a timeout expiring in the same cycle
        if (pready || (TO_EN && (tcnt_q == TLAST))) begin
          rsp_valid_d   = 1'b1;
          rsp_err_d     = pready ? pslverr : 1'b1;
          rsp_timeout_d = !pready;
          rsp_rdata_d   = (pready && !pwrite_q && !pslverr) ? prdata : '0;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = IDLE;
          xfer_d        = (xfer_q == '1) ? xfer_q : xfer_q + CNT_WIDTH'(1);
          if (!pready || pslverr) begin
            errc_d = (errc_q == '1) ? errc_q : errc_q + CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      xfer_q        <= '0;
      errc_q        <= '0;
      tcnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      xfer_q        <= xfer_d;
      errc_q        <= errc_d;
      tcnt_q        <= tcnt_d;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge against a 16-register APB slave model.
module tb_apb_master_bridge;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [7:0]  rsp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr;
  logic [7:0]  pwdata;
  logic        pready, pslverr;
  logic [7:0]  prdata;
  logic [15:0] xfer_count, err_count;

  apb_master_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16), .CNT_WIDTH(16)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .xfer_count(xfer_count), .err_count(err_count)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        err;
    logic        to;
    int          lat;
    int          acc;
  } exp_t;

  exp_t       exp_q[$];
  int         acc_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         cfg_wait = 0;
  int         s_cnt = 0;
  int         mon_acc = 0;
  int         mon_setup = 0;
  logic       prev_psel = 1'b0;
  logic [7:0] mem [16];
  exp_t       me;
  int         ma;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Slave: 16 registers, out-of-range address errors; junk driven outside ACCESS
  initial for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  always @(negedge pclk) begin
    if (psel && penable) begin
      logic rdy, bad;
      rdy = (s_cnt >= cfg_wait);
      bad = (paddr >= 32'd16);
      s_cnt++;
      pready  = rdy;
      pslverr = rdy && bad;
      prdata  = (rdy && !pwrite && !bad) ? mem[paddr[3:0]] : 8'hEE;
      if (rdy && pwrite && !bad) mem[paddr[3:0]] = pwdata;
    end else begin
      s_cnt   = 0;
      pready  = 1'b1;
      pslverr = 1'b1;
      prdata  = 8'hFF;
    end
  end

  // Monitor: accepts, APB phase checks, and response scoreboard
  always @(negedge pclk) begin
    if (presetn) begin
      if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
      if (psel) begin
        if (exp_q.size() == 0) flag("psel_unexpected");
        else begin
          check("paddr_stable", paddr, exp_q[0].addr);
          check("pwrite_stable", {31'd0, pwrite}, {31'd0, exp_q[0].w});
          if (exp_q[0].w) check("pwdata_stable", {24'd0, pwdata}, {24'd0, exp_q[0].wdata});
        end
        if (penable) mon_acc++;
        else begin
          mon_setup++;
          check("psel_gap", {31'd0, prev_psel}, 32'd0);
        end
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) flag("spurious_rsp");
        else begin
          me = exp_q.pop_front();
          ma = acc_q.pop_front();
          check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, me.rdata});
          check("rsp_err", {31'd0, rsp_err}, {31'd0, me.err});
          check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, me.to});
          check("latency", cyc - ma, me.lat);
          check("access_cycles", mon_acc, me.acc);
          check("setup_cycles", mon_setup, 1);
          check("psel_in_rsp", {31'd0, psel}, 32'd0);
          check("ready_in_rsp", {31'd0, cmd_ready}, 32'd1);
        end
        mon_acc   = 0;
        mon_setup = 0;
      end
    end
    prev_psel = psel;
  end

  // Call at posedge+1; returns at posedge+1 after the accept edge, cmd_valid left high
  task automatic send(input bit w, input logic [31:0] a, input logic [7:0] d,
                      input logic [7:0] er, input bit ee, input bit et,
                      input int lat, input int acc, output int acyc);
    exp_t e;
    e = '{w:w, addr:a, wdata:d, rdata:er, err:ee, to:et, lat:lat, acc:acc};
    exp_q.push_back(e);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    acyc = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge pclk);
      if (cmd_ready) begin
        acyc = cyc;
        break;
      end
    end
    if (acyc < 0) flag("accept_timeout");
    @(posedge pclk);
    #1;
  endtask

  task automatic drain_check(input int xc, input int ec);
    int n;
    cmd_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge pclk);
      n++;
    end
    if (exp_q.size() != 0) flag("drain_timeout");
    @(negedge pclk);
    check("xfer_count", {16'd0, xfer_count}, xc);
    check("err_count", {16'd0, err_count}, ec);
    @(posedge pclk);
    #1;
  endtask

  initial begin
    int a0, a1, a2, a3;
    presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("rst_psel", {31'd0, psel}, 0);
    check("rst_penable", {31'd0, penable}, 0);
    check("rst_pwrite", {31'd0, pwrite}, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", {24'd0, pwdata}, 0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    check("rst_rsp", {29'd0, rsp_err, rsp_timeout, |rsp_rdata}, 0);
    check("rst_counts", {xfer_count, err_count}, 0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 0);
    @(posedge pclk); #1 presetn = 1'b1;
    @(negedge pclk);
    check("idle_cmd_ready", {31'd0, cmd_ready}, 1);
    @(posedge pclk); #1;

    // write then read, zero-wait
    cfg_wait = 0;
    send(1, 3, 8'hA5, 8'h00, 0, 0, 3, 1, a0);
    cmd_valid = 1'b0;
    send(0, 3, 8'h00, 8'hA5, 0, 0, 3, 1, a0);
    drain_check(2, 0);

    // slave errors: out-of-range write and read (read data forced to 0)
    send(1, 20, 8'h11, 8'h00, 1, 0, 3, 1, a0);
    drain_check(3, 1);
    send(0, 30, 8'h00, 8'h00, 1, 0, 3, 1, a0);
    drain_check(4, 2);

    // 3 wait states on a read
    send(1, 5, 8'h5C, 8'h00, 0, 0, 3, 1, a0);
    drain_check(5, 2);
    cfg_wait = 3;
    send(0, 5, 8'h00, 8'h5C, 0, 0, 6, 4, a0);
    drain_check(6, 2);

    // timeout, then pready on the 16th ACCESS cycle
    cfg_wait = 1000;
    send(0, 7, 8'h00, 8'h00, 1, 1, 18, 16, a0);
    drain_check(7, 3);
    cfg_wait = 15;
    send(0, 3, 8'h00, 8'hA5, 0, 0, 18, 16, a0);
    drain_check(8, 3);

    // back-to-back with cmd_valid held high
    cfg_wait = 0;
    send(1, 8, 8'h3C, 8'h00, 0, 0, 3, 1, a0);
    send(1, 9, 8'hC3, 8'h00, 0, 0, 3, 1, a1);
    send(0, 8, 8'h00, 8'h3C, 0, 0, 3, 1, a2);
    send(0, 9, 8'h00, 8'hC3, 0, 0, 3, 1, a3);
    check("b2b_space1", a1 - a0, 3);
    check("b2b_space2", a2 - a1, 3);
    check("b2b_space3", a3 - a2, 3);
    drain_check(12, 3);

    // reset during ACCESS drops the transfer
    cfg_wait = 1000;
    send(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, a0);
    cmd_valid = 1'b0;
    repeat (3) @(posedge pclk);
    #1 presetn = 1'b0;
    @(posedge pclk); #1 presetn = 1'b1;
    exp_q.delete();
    acc_q.delete();
    mon_acc = 0;
    mon_setup = 0;
    @(negedge pclk);
    check("mid_psel", {31'd0, psel}, 0);
    check("mid_penable", {31'd0, penable}, 0);
    check("mid_paddr", paddr, 0);
    check("mid_rsp_valid", {31'd0, rsp_valid}, 0);
    check("mid_rsp", {29'd0, rsp_err, rsp_timeout, |rsp_rdata}, 0);
    check("mid_counts", {xfer_count, err_count}, 0);
    check("mid_cmd_ready", {31'd0, cmd_ready}, 1);
    repeat (5) @(negedge pclk);
    cfg_wait = 0;
    @(posedge pclk); #1;
    send(0, 3, 8'h00, 8'hA5, 0, 0, 3, 1, a0);
    drain_check(1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
